// File: rtl/my_or.sv
// my_or: bitwise OR of two operand buses with registered companions.
// The combinational output 'op' has no clock or reset dependency, so the
// block also works in purely combinational benches. The registered
// outputs are a one-cycle pipelined copy of 'op', a per-bit sticky
// accumulator and a saturating count of cycles in which any bit of 'op'
// was high. 'clear' restarts the accumulator and the counter. The
// current cycle's 'op' is still folded in, so a clear never drops an event.
module my_or #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             clear,
    output logic [WIDTH-1:0] op,
    output logic [WIDTH-1:0] op_q,
    output logic [WIDTH-1:0] op_sticky,
    output logic [CNT_W-1:0] hi_count
);

    logic any_hi;
    logic cnt_full;

    // Pure combinational OR; X/Z follow normal OR semantics.
    assign op       = input1 | input2;
    assign any_hi   = |op;
    assign cnt_full = (hi_count == {CNT_W{1'b1}});

    // One-cycle registered copy of op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0;
        end else begin
            op_q <= op;
        end
    end

    // Sticky accumulator; a clear reloads with the current op instead of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_sticky <= '0;
        end else if (clear) begin
            op_sticky <= op;
        end else begin
            op_sticky <= op_sticky | op;
        end
    end

    // Count of cycles with any op bit high; reloads on clear, holds once saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_count <= '0;
        end else if (clear) begin
            hi_count <= CNT_W'(any_hi);
        end else if (any_hi && !cnt_full) begin
            hi_count <= hi_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_my_or.sv
// tb_my_or: self-checking bench for my_or. A 4-bit instance with a 3-bit
// counter carries the sequential tests against a reference model kept as
// plain integers. A default-parameter instance covers the 1-bit truth table.
module tb_my_or;

    localparam int W  = 4;
    localparam int CW = 3;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  input1;
    logic [W-1:0]  input2;
    logic          clear;
    logic [W-1:0]  op;
    logic [W-1:0]  op_q;
    logic [W-1:0]  op_sticky;
    logic [CW-1:0] hi_count;

    logic          in1_s;
    logic          in2_s;
    logic          op_s;
    logic          op_q_s;
    logic          op_sticky_s;
    logic [7:0]    hi_count_s;

    int n_vectors = 0;
    int n_miscompares = 0;

    // Reference model state: unbounded counter, sticky value and pipeline copy.
    int           ref_count;
    logic [W-1:0] ref_sticky;
    logic [W-1:0] ref_q;

    my_or #(.WIDTH(W), .CNT_W(CW)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .input1    (input1),
        .input2    (input2),
        .clear     (clear),
        .op        (op),
        .op_q      (op_q),
        .op_sticky (op_sticky),
        .hi_count  (hi_count)
    );

    my_or u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .input1    (in1_s),
        .input2    (in2_s),
        .clear     (1'b0),
        .op        (op_s),
        .op_q      (op_q_s),
        .op_sticky (op_sticky_s),
        .hi_count  (hi_count_s)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_vectors++;
        if (observed !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int expected_count();
        return (ref_count > CNT_MAX) ? CNT_MAX : ref_count;
    endfunction

    task automatic model_reset();
        ref_count  = 0;
        ref_sticky = '0;
        ref_q      = '0;
    endtask

    // Called just after a falling edge: drive, check op, clock once, check registers.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic clr);
        logic [W-1:0] exp_op;
        input1 = a;
        input2 = b;
        clear  = clr;
        exp_op = '0;
        for (int i = 0; i < W; i++) exp_op[i] = a[i] || b[i];
        #1;
        checkOutput("op", op, exp_op);
        @(posedge clk);
        ref_q = exp_op;
        if (clr) begin
            ref_sticky = exp_op;
            ref_count  = (exp_op != 0) ? 1 : 0;
        end else begin
            ref_sticky = ref_sticky | exp_op;
            ref_count  = ref_count + ((exp_op != 0) ? 1 : 0);
        end
        @(negedge clk);
        checkOutput("op_q", op_q, ref_q);
        checkOutput("op_sticky", op_sticky, ref_sticky);
        checkOutput("hi_count", hi_count, expected_count());
    endtask

    // Called just after a falling edge: pulse reset between edges and check it bites at once.
    task automatic pulseReset();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_async_op_q", op_q, 0);
        checkOutput("rst_async_sticky", op_sticky, 0);
        checkOutput("rst_async_count", hi_count, 0);
        checkOutput("rst_op_live", op, input1 | input2);
        model_reset();
        @(posedge clk);
        #1;
        checkOutput("rst_hold_count", hi_count, 0);
        checkOutput("rst_hold_op_q", op_q, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Main sequence: truth table, reset, directed scenarios, then random traffic.
    initial begin
        logic [1:0] tt_in [4];
        logic       tt_exp [4];
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;

        rst_n  = 1'b0;
        input1 = '0;
        input2 = '0;
        clear  = 1'b0;
        in1_s  = 1'b0;
        in2_s  = 1'b0;
        model_reset();

        tt_in[0] = 2'b00; tt_exp[0] = 1'b0;
        tt_in[1] = 2'b10; tt_exp[1] = 1'b1;
        tt_in[2] = 2'b01; tt_exp[2] = 1'b1;
        tt_in[3] = 2'b11; tt_exp[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in1_s = tt_in[i][1];
            in2_s = tt_in[i][0];
            #1;
            checkOutput("truth_table", op_s, tt_exp[i]);
        end
        in1_s = 1'bx;
        in2_s = 1'b1;
        #1;
        checkOutput("x_or_one", op_s, 1'b1);
        in2_s = 1'b0;
        #1;
        checkOutput("x_or_zero", op_s, 1'bx);
        in1_s = 1'b0;

        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_op_q", op_q, 0);
        checkOutput("reset_sticky", op_sticky, 0);
        checkOutput("reset_count", hi_count, 0);
        rst_n = 1'b1;

        applyStimulus(4'b0101, 4'b0010, 1'b0);
        checkOutput("pipe_0111", op_q, 4'b0111);

        applyStimulus(4'b0000, 4'b0000, 1'b1);
        applyStimulus(4'b0001, 4'b0000, 1'b0);
        applyStimulus(4'b0000, 4'b1000, 1'b0);
        checkOutput("sticky_1001", op_sticky, 4'b1001);
        applyStimulus(4'b0100, 4'b0000, 1'b1);
        checkOutput("sticky_clear_0100", op_sticky, 4'b0100);

        pulseReset();
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(4'b0001, 4'b0000, 1'b0);
            checkOutput("sat_seq", hi_count, (i > 7) ? 7 : i);
        end
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        checkOutput("clear_zero", hi_count, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus((i % 2 == 0) ? 4'b0010 : 4'b0000, 4'b0000, 1'b0);
        end
        checkOutput("hold_alt_3", hi_count, 3);

        for (int i = 0; i < 300; i++) begin
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(0, (1 << W) - 1));
            if ($urandom_range(0, 3) == 0) begin
                ra = '0;
                rb = '0;
            end
            rc = ($urandom_range(0, 7) == 0);
            if (i == 150) pulseReset();
            applyStimulus(ra, rb, rc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/my_or.md
# my_or

Two-input OR gate block with a combinational output plus registered companion outputs: a pipelined copy, a sticky accumulator and a saturating high-cycle counter. Used in the gate-level lab datapath wherever a bitwise OR of two operand buses is needed alongside a clean registered version and simple activity statistics. The combinational path is independent of clock and reset. It is usable in purely combinational benches that never toggle `clk` or `rst_n`.

## Interface

Parameters:
- `WIDTH`, default 1: bit width of `input1`, `input2`, `op`, `op_q` and `op_sticky`.
- `CNT_W`, default 8: width of `hi_count`.

Ports:
- `clk`, input, 1: single system clock; all registers update on its rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `input1`, input, WIDTH: operand A.
- `input2`, input, WIDTH: operand B.
- `clear`, input, 1: synchronous clear of `op_sticky` and `hi_count`.
- `op`, output, WIDTH: combinational `input1 | input2`, bitwise.
- `op_q`, output, WIDTH: `op` registered by one cycle.
- `op_sticky`, output, WIDTH: per-bit OR-accumulation of `op` since the last reset or clear.
- `hi_count`, output, CNT_W: number of cycles with any bit of `op` high, saturating.

## Operation

- `op` is the pure combinational bitwise OR of the operands.
  - No clock or reset dependency.
  - Settles within the same delta/timestep as an input change.
  - 1-bit truth table: 00→0, 10→1, 01→1, 11→1.
- X/Z on an operand bit propagates per standard OR semantics: 1|X=1, 0|X=X.
- `op_q`: on each rising `clk`, `op_q <= op`.
- `op_sticky`:
  - On each rising `clk`, `op_sticky <= clear ? op : (op_sticky | op)`.
  - The cycle's own `op` is included even when `clear` is asserted, so a clear never drops an event.
- `hi_count`:
  - On each rising `clk`, if `clear`, load `(|op) ? 1 : 0`.
  - Otherwise, if `|op`, increment, saturating at all-ones and holding there.
  - Otherwise hold.
- Reset (`rst_n` low, asynchronous):
  - `op_q` = 0, `op_sticky` = 0, `hi_count` = 0 immediately, without waiting for a clock edge.
  - Registers stay at 0 while `rst_n` is low.
  - `op` continues to follow the inputs during reset.
- Reset release is synchronous-safe: the first update happens on the first rising `clk` after `rst_n` goes high.
- Reset asserted mid-operation: all registered state is lost. There is no recovery of the counter or sticky value.
- `WIDTH` must be ≥ 1 and `CNT_W` ≥ 1. The block has no other configuration.

## Timing

- `op`: zero-cycle, combinational latency.
- `op_q`, `op_sticky`, `hi_count`: one-cycle latency. Each reflects the `op` and `clear` values sampled at the preceding rising edge.
- No handshake; inputs are sampled every cycle.
- `clear` and `|op` in the same cycle: `clear` takes priority for the base value, and the current cycle's `op` is still counted/accumulated as described above.
- Saturation: when `hi_count` is all-ones and `|op` is 1 with no `clear`, `hi_count` remains all-ones.
- No internal state machine.

## Test plan

- Combinational truth table, no clock, `rst_n` undriven or high, `WIDTH`=1: apply (0,0), (1,0), (0,1), (1,1), each held 1 time unit → `op` = 0, 1, 1, 1 respectively at each check point.
- Async reset: with registers non-zero, drop `rst_n` between clock edges → `op_q`, `op_sticky`, `hi_count` all 0 immediately. `op` still equals `input1|input2`.
- Pipeline: `WIDTH`=4, drive `input1`=4'b0101, `input2`=4'b0010 → `op`=4'b0111 immediately, `op_q`=4'b0111 after the next rising edge.
- Sticky and clear:
  - Drive `op`=4'b0001, then 4'b1000 over two cycles → `op_sticky`=4'b1001.
  - Then `clear`=1 with `op`=4'b0100 → `op_sticky`=4'b0100 next cycle.
- Counter saturation: `CNT_W`=3, hold `input1`=1 for 10 cycles after reset → `hi_count` reads 1..7 and then stays at 7. A `clear` with `op`=0 → 0.
- Counter hold: alternate `op` high and low for 6 cycles starting from 0 → `hi_count`=3.
